// File: rtl/matrix_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_sequencer_pkg
//  Description : Shared constants and types for the matrix instruction
//                sequencer: opcode values, write-data mux selects, default
//                index width and the sequencer state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package matrix_sequencer_pkg;

    // Default matrix index width when the instantiating level does not override.
    localparam int C_INDEX_BIT_DEFAULT = 4;

    // Opcode 0 is a plain copy of src1 into dst; 1..7 are handed to the ALU.
    localparam logic [2:0] C_OP_COPY = 3'd0;

    // Write-data mux selects seen by the memory write port.
    localparam logic [1:0] C_WSEL_HOST = 2'b00;
    localparam logic [1:0] C_WSEL_ALU  = 2'b01;
    localparam logic [1:0] C_WSEL_COPY = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WRITE = 2'd3
    } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/matrix_sequencer_write_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : write_port_arbiter
//  Description : Owner select for the single memory write port, shared by the
//                sequencer write-back and the host loader. The host may write
//                in IDLE, and in EXEC as long as it does not touch a matrix
//                the in-flight instruction reads or writes.
//  Ports       : i state            - sequencer state
//                i is_copy          - in-flight instruction is a COPY
//                i imm              - src2 is generated, not read
//                i src1/src2/dst    - in-flight matrix indices
//                i host_wr_valid    - host write request
//                i host_wr_index    - host target matrix
//                o host_wr_ready    - host write accepted this cycle
//                o write            - memory write index
//                o write_enable     - memory write strobe
//                o wdata_sel        - write-data mux select
//  Revision    : 1.0 - initial release
// ============================================================================
module write_port_arbiter
    import matrix_sequencer_pkg::*;
#(
    parameter int INDEX_BIT = C_INDEX_BIT_DEFAULT
) (
    input  seq_state_e           state,
    input  logic                 is_copy,
    input  logic                 imm,
    input  logic [INDEX_BIT-1:0] src1,
    input  logic [INDEX_BIT-1:0] src2,
    input  logic [INDEX_BIT-1:0] dst,
    input  logic                 host_wr_valid,
    input  logic [INDEX_BIT-1:0] host_wr_index,
    output logic                 host_wr_ready,
    output logic [INDEX_BIT-1:0] write,
    output logic                 write_enable,
    output logic [1:0]           wdata_sel
);

    logic w_host_hazard;
    logic w_host_wr;

    always_comb begin
        // An immediate src2 is never read from memory, so it cannot conflict.
        w_host_hazard = (host_wr_index == src1) ||
                        (host_wr_index == dst)  ||
                        (!imm && (host_wr_index == src2));

        unique case (state)
            ST_IDLE: host_wr_ready = 1'b1;
            ST_EXEC: host_wr_ready = !w_host_hazard;
            default: host_wr_ready = 1'b0;
        endcase

        w_host_wr = host_wr_valid && host_wr_ready;

        write        = '0;
        write_enable = 1'b0;
        wdata_sel    = C_WSEL_HOST;
        // Host is never ready in WRITE, so the two owners cannot collide.
        if (state == ST_WRITE) begin
            write_enable = 1'b1;
            write        = dst;
            wdata_sel    = is_copy ? C_WSEL_COPY : C_WSEL_ALU;
        end else if (w_host_wr) begin
            write_enable = 1'b1;
            write        = host_wr_index;
        end
    end

endmodule
`default_nettype wire

// File: rtl/matrix_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_sequencer
//  Description : Single-issue controller that steps one matrix instruction at
//                a time through memory read, ALU execution (watchdog bounded)
//                and write-back, sharing the memory write port with a host.
//  Ports       : CLK, RST (async, active low)
//                instr_*           - instruction valid/ready and fields
//                host_wr_*         - host write request/ready/index
//                read1/read2/write - memory indices
//                write_enable, generated_enable, wdata_sel - memory controls
//                alu_start/alu_op/alu_done - ALU handshake
//                busy, timeout_err, retired - status
//  Revision    : 1.0 - initial release
// ============================================================================
module matrix_sequencer
    import matrix_sequencer_pkg::*;
#(
    parameter int INDEX_BIT = C_INDEX_BIT_DEFAULT,
    parameter int TIMEOUT   = 255
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic [2:0]           instr_op,
    input  logic [INDEX_BIT-1:0] instr_dst,
    input  logic [INDEX_BIT-1:0] instr_src1,
    input  logic [INDEX_BIT-1:0] instr_src2,
    input  logic                 instr_imm,
    input  logic                 host_wr_valid,
    output logic                 host_wr_ready,
    input  logic [INDEX_BIT-1:0] host_wr_index,
    output logic [INDEX_BIT-1:0] read1,
    output logic [INDEX_BIT-1:0] read2,
    output logic [INDEX_BIT-1:0] write,
    output logic                 write_enable,
    output logic                 generated_enable,
    output logic [1:0]           wdata_sel,
    output logic                 alu_start,
    output logic [2:0]           alu_op,
    input  logic                 alu_done,
    output logic                 busy,
    output logic                 timeout_err,
    output logic [15:0]          retired
);

    // Watchdog counts completed EXEC cycles from 0; the abort fires on the
    // TIMEOUT-th EXEC cycle, i.e. when the count already equals TIMEOUT-1.
    localparam logic [7:0] C_WD_LAST = 8'(TIMEOUT - 1);

    seq_state_e           state_q, state_d;
    logic [2:0]           op_q, op_d;
    logic [INDEX_BIT-1:0] dst_q, dst_d;
    logic [INDEX_BIT-1:0] src1_q, src1_d;
    logic [INDEX_BIT-1:0] src2_q, src2_d;
    logic                 imm_q, imm_d;
    logic [7:0]           wd_q, wd_d;
    logic                 timeout_err_q, timeout_err_d;
    logic [15:0]          retired_q, retired_d;

    logic                 w_instr_ready;
    logic                 w_is_copy;

    assign w_is_copy     = (op_q == C_OP_COPY);
    // Host has priority over a new instruction while idle.
    assign w_instr_ready = (state_q == ST_IDLE) && !host_wr_valid;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q       <= ST_IDLE;
            op_q          <= '0;
            dst_q         <= '0;
            src1_q        <= '0;
            src2_q        <= '0;
            imm_q         <= 1'b0;
            wd_q          <= '0;
            timeout_err_q <= 1'b0;
            retired_q     <= '0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            dst_q         <= dst_d;
            src1_q        <= src1_d;
            src2_q        <= src2_d;
            imm_q         <= imm_d;
            wd_q          <= wd_d;
            timeout_err_q <= timeout_err_d;
            retired_q     <= retired_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        dst_d         = dst_q;
        src1_d        = src1_q;
        src2_d        = src2_q;
        imm_d         = imm_q;
        wd_d          = wd_q;
        timeout_err_d = timeout_err_q;
        retired_d     = retired_q;

        unique case (state_q)
            ST_IDLE: begin
                if (instr_valid && w_instr_ready) begin
                    op_d    = instr_op;
                    dst_d   = instr_dst;
                    src1_d  = instr_src1;
                    src2_d  = instr_src2;
                    imm_d   = instr_imm;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                wd_d    = '0;
                state_d = w_is_copy ? ST_WRITE : ST_EXEC;
            end
            ST_EXEC: begin
                // Completion takes precedence over an expiring watchdog.
                if (alu_done) begin
                    state_d = ST_WRITE;
                end else if (wd_q == C_WD_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    wd_d = wd_q + 8'd1;
                end
            end
            ST_WRITE: begin
                retired_d = retired_q + 16'd1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    write_port_arbiter #(
        .INDEX_BIT (INDEX_BIT)
    ) u_write_port_arbiter (
        .state         (state_q),
        .is_copy       (w_is_copy),
        .imm           (imm_q),
        .src1          (src1_q),
        .src2          (src2_q),
        .dst           (dst_q),
        .host_wr_valid (host_wr_valid),
        .host_wr_index (host_wr_index),
        .host_wr_ready (host_wr_ready),
        .write         (write),
        .write_enable  (write_enable),
        .wdata_sel     (wdata_sel)
    );

    assign instr_ready      = w_instr_ready;
    assign read1            = src1_q;
    assign read2            = src2_q;
    // Only drive the generated path while an instruction owns the read ports.
    assign generated_enable = imm_q && (state_q != ST_IDLE);
    assign alu_start        = (state_q == ST_ISSUE) && !w_is_copy;
    assign alu_op           = op_q;
    assign busy             = (state_q != ST_IDLE);
    assign timeout_err      = timeout_err_q;
    assign retired          = retired_q;

endmodule
`default_nettype wire

// File: doc/matrix_sequencer.md
# matrix_sequencer

Single-issue controller that sequences matrix instructions through the matrix memory and the matrix ALU, and shares the memory's single write port with a host loader. It accepts one instruction at a time over a valid/ready handshake and drives the memory read/write indices, `write_enable` and `generated_enable`. It then starts the ALU, waits for completion (bounded by a watchdog), and writes the result back. It sits between the instruction front end and the `memory`/ALU datapath.

## Interface
- `INDEX_BIT`, default `` `INDEX_BIT `` (from CONSTANT.v): matrix index width.
- `TIMEOUT`, default 255: maximum EXEC cycles before abort; range 1..255.
- `CLK` in 1: single clock, rising edge.
- `RST` in 1: asynchronous, active-low reset (asserted when 0).
- `instr_valid` in 1: instruction offered.
- `instr_ready` out 1: instruction accepted when `instr_valid & instr_ready` at a rising edge.
- `instr_op` in 3: 0 = COPY, 1..7 = ALU opcodes, passed through.
- `instr_dst` in INDEX_BIT: destination matrix.
- `instr_src1` in INDEX_BIT: source matrix 1.
- `instr_src2` in INDEX_BIT: source matrix 2, or the immediate value when `instr_imm` = 1.
- `instr_imm` in 1: src2 is generated (broadcast) instead of read.
- `host_wr_valid` in 1: host requests a write.
- `host_wr_ready` out 1: host write performed this cycle when both are high.
- `host_wr_index` in INDEX_BIT: host target matrix.
- `read1` out INDEX_BIT: memory read1.
- `read2` out INDEX_BIT: memory read2.
- `write` out INDEX_BIT: memory write index.
- `write_enable` out 1: memory write strobe.
- `generated_enable` out 1: memory generated_enable.
- `wdata_sel` out 2: write-data mux select: 00 host, 01 ALU result, 10 data1 (COPY).
- `alu_start` out 1: one-cycle start pulse.
- `alu_op` out 3: latched opcode.
- `alu_done` in 1: ALU result valid, sampled in EXEC.
- `busy` out 1: state ≠ IDLE.
- `timeout_err` out 1: sticky; set on watchdog abort, cleared only by reset.
- `retired` out 16: count of completed instructions; wraps modulo 2^16.

## Operation
- States: IDLE, ISSUE, EXEC, WRITE.
- Instruction fields are latched on acceptance. `read1`=src1, `read2`=src2 and `generated_enable`=imm are held from ISSUE until WRITE completes.
- IDLE: `instr_ready` = ~`host_wr_valid`. Host has priority in IDLE. On accept go to ISSUE.
- ISSUE: for an ALU op, pulse `alu_start`, clear the watchdog and go to EXEC. For COPY, skip the ALU and go to WRITE.
- EXEC: wait for `alu_done`.
  - If `alu_done` = 1, go to WRITE.
  - Otherwise the watchdog increments. When it reaches TIMEOUT, set `timeout_err`, return to IDLE with no write and no `retired` increment.
  - `alu_done` and timeout on the same cycle: done wins.
- WRITE: for one cycle, `write_enable`=1, `write`=dst, `wdata_sel`=01 (ALU) or 10 (COPY). Increment `retired`, go to IDLE.
- Host write port:
  - `host_wr_ready` = 1 in IDLE, and in EXEC when `host_wr_index` ≠ src1, ≠ dst, and (imm or ≠ src2). Otherwise 0.
  - Always 0 in ISSUE and WRITE.
  - A host write drives `write`=`host_wr_index`, `wdata_sel`=00, `write_enable`=1 that cycle.
- Sequencer ownership: `read1`/`read2` are don't-care in IDLE (hold last value); `write_enable`=0 whenever neither owner writes.
- `alu_done` outside EXEC is ignored.

## Timing
- Reset values:
  - state = IDLE; all index outputs = 0.
  - `write_enable`, `generated_enable`, `alu_start`, `alu_op`, `timeout_err`, `retired` = 0; `wdata_sel` = 00; `busy` = 0.
  - `instr_ready` = 1 and `host_wr_ready` = 1 immediately after reset release (combinational from IDLE).
- ALU op latency:
  - Accept at edge 0; ISSUE in cycle 1 (`alu_start`); EXEC from cycle 2.
  - `alu_done` seen in cycle k, WRITE in cycle k+1, IDLE in k+2.
  - Minimum 4 cycles accept-to-accept.
- COPY: accept at 0, ISSUE at 1, WRITE at 2, next accept at edge 3.
- Reset mid-operation: immediate abort. No write is issued and `retired` clears.
- `instr_ready` is never high outside IDLE, so back-to-back instructions stall without loss.

## Structure
- CONSTANT.v (shared): add the opcode constants (OP_COPY = 0) and the state encoding; reuse INDEX_BIT/WIDTH_BIT.
- Sub-module `write_port_arbiter`: the combinational owner select for the write port plus the host hazard compare. The FSM, watchdog and counters stay in `matrix_sequencer`.

## Test plan
- ALU op (op=1, src1=2, src2=3, dst=4, `alu_done` 3 cycles after start) -> `alu_start` in cycle 1; write to index 4 with `wdata_sel`=01 one cycle after done; `retired`=1.
- COPY src1=5, dst=6 -> no `alu_start`; WRITE in cycle 2 with `wdata_sel`=10, `write`=6; next instruction accepted at edge 3.
- IDLE with `host_wr_valid` and `instr_valid` both high -> host write to its index, `instr_ready`=0; instruction accepted next cycle.
- During EXEC (src1=2, dst=4, imm=1, src2=7), host index 7 -> accepted; host index 2 or 4 -> `host_wr_ready`=0 until WRITE completes.
- `alu_done` never asserted, TIMEOUT=8 -> return to IDLE after 8 EXEC cycles; `timeout_err`=1; no `write_enable`; `retired` unchanged.
- `RST` low in EXEC -> all outputs at reset values asynchronously; after release, a new instruction completes normally.
